// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared state encoding and constants for the fetch PC controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_PC_INC           = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-fetch-address selection from the BTB answer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
    import fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        btb_valid,
    input  logic        btb_taken,
    input  logic [31:0] btb_target,
    output logic        pred_taken,
    output logic [31:0] pred_next
);

    assign pred_taken = btb_valid && btb_taken;
    assign pred_next  = pred_taken ? btb_target : (pc + C_PC_INC);

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch-stage PC owner; one outstanding imem request, one-entry
//               decode output register, execute redirect with response drop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_redirect_en,
    input  logic [31:0] ex_redirect_pc,
    output logic [31:0] btb_lookup_pc,
    input  logic        btb_pc_valid,
    input  logic        btb_pc_predictTaken,
    input  logic [31:0] btb_target_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic         r_req_valid;
    logic         r_pred_taken;
    logic [31:0]  r_pred_next;
    logic         r_id_valid;
    logic [31:0]  r_id_pc;
    logic [31:0]  r_id_instr;
    logic         r_id_pred_taken;
    logic [31:0]  r_id_pred_target;

    logic         w_pred_taken;
    logic [31:0]  w_pred_next;
    logic         w_req_fire;
    logic         w_resp_ready;
    logic         w_resp_fire;
    logic         w_wait_fire;
    logic [31:0]  w_redirect_pc;
    logic         w_unused_bits;

    fetch_next_pc u_next_pc (
        .pc         (r_fetch_pc),
        .btb_valid  (btb_pc_valid),
        .btb_taken  (btb_pc_predictTaken),
        .btb_target (btb_target_pc),
        .pred_taken (w_pred_taken),
        .pred_next  (w_pred_next)
    );

    assign w_req_fire    = (r_state == ST_REQ) && r_req_valid && imem_req_ready;
    assign w_resp_ready  = !rst && (((r_state == ST_WAIT) && (!r_id_valid || id_ready)) ||
                                    (r_state == ST_DROP));
    assign w_resp_fire   = imem_resp_valid && w_resp_ready;
    assign w_wait_fire   = (r_state == ST_WAIT) && w_resp_fire;
    assign w_redirect_pc = {ex_redirect_pc[31:2], 2'b00};
    assign w_unused_bits = ^ex_redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_req_fire) begin
                        r_state     <= ex_redirect_en ? ST_DROP : ST_WAIT;
                        r_req_valid <= 1'b0;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A response in the redirect cycle is swallowed here instead of in DROP.
                    if (w_resp_fire) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                    end else if (ex_redirect_en) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (w_resp_fire) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_REQ;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_pred_taken <= 1'b0;
            r_pred_next  <= 32'd0;
        end else begin
            if (w_req_fire) begin
                r_pred_taken <= w_pred_taken;
                r_pred_next  <= w_pred_next;
            end
            if (ex_redirect_en) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_wait_fire) begin
                r_fetch_pc <= r_pred_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid       <= 1'b0;
            r_id_pc          <= 32'd0;
            r_id_instr       <= 32'd0;
            r_id_pred_taken  <= 1'b0;
            r_id_pred_target <= 32'd0;
        end else if (ex_redirect_en) begin
            r_id_valid <= 1'b0;
        end else if (w_wait_fire) begin
            r_id_valid       <= 1'b1;
            r_id_pc          <= r_fetch_pc;
            r_id_instr       <= imem_resp_data;
            r_id_pred_taken  <= r_pred_taken;
            r_id_pred_target <= r_pred_next;
        end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign btb_lookup_pc   = r_fetch_pc;
    assign imem_req_valid  = r_req_valid;
    assign imem_req_addr   = r_fetch_pc;
    assign imem_resp_ready = w_resp_ready;
    assign id_valid        = r_id_valid;
    assign id_pc           = r_id_pc;
    assign id_instr        = r_id_instr;
    assign id_pred_taken   = r_id_pred_taken;
    assign id_pred_target  = r_id_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Scoreboard bench for fetch_pc_ctrl with a simple memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_redirect_en;
    logic [31:0] ex_redirect_pc;
    logic [31:0] btb_lookup_pc;
    logic        btb_pc_valid;
    logic        btb_pc_predictTaken;
    logic [31:0] btb_target_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } id_exp_t;

    logic [31:0] exp_req_q[$];
    id_exp_t     exp_id_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fire_cyc = 0;
    int last_gap = 0;
    int mem_delay = 0;

    logic        btb_en;
    logic [31:0] btb_hit_pc;
    logic [31:0] btb_tgt;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_redirect_en      (ex_redirect_en),
        .ex_redirect_pc      (ex_redirect_pc),
        .btb_lookup_pc       (btb_lookup_pc),
        .btb_pc_valid        (btb_pc_valid),
        .btb_pc_predictTaken (btb_pc_predictTaken),
        .btb_target_pc       (btb_target_pc),
        .imem_req_valid      (imem_req_valid),
        .imem_req_ready      (imem_req_ready),
        .imem_req_addr       (imem_req_addr),
        .imem_resp_valid     (imem_resp_valid),
        .imem_resp_ready     (imem_resp_ready),
        .imem_resp_data      (imem_resp_data),
        .id_valid            (id_valid),
        .id_ready            (id_ready),
        .id_pc               (id_pc),
        .id_instr            (id_instr),
        .id_pred_taken       (id_pred_taken),
        .id_pred_target      (id_pred_target)
    );

    assign btb_pc_valid        = btb_en && (btb_lookup_pc == btb_hit_pc);
    assign btb_pc_predictTaken = 1'b1;
    assign btb_target_pc       = btb_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory model: one outstanding request, response after mem_delay extra cycles.
    initial begin : memory
        logic        req_fire;
        logic        resp_fire;
        logic [31:0] req_a;
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        pend  = 1'b0;
        paddr = 32'd0;
        cnt   = 0;
        forever begin
            @(negedge clk);
            req_fire  = imem_req_valid && imem_req_ready;
            resp_fire = imem_resp_valid && imem_resp_ready;
            req_a     = imem_req_addr;
            @(posedge clk);
            #1;
            if (rst) begin
                imem_resp_valid = 1'b0;
                pend = 1'b0;
            end else begin
                if (resp_fire) imem_resp_valid = 1'b0;
                if (req_fire) begin
                    pend  = 1'b1;
                    paddr = req_a;
                    cnt   = mem_delay;
                end
                if (pend && !imem_resp_valid) begin
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_word(paddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: pops expected request addresses and decode words on handshakes.
    initial begin : monitor
        logic [31:0] ea;
        id_exp_t     ei;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        fail_now("req_unexpected");
                    end else begin
                        ea = exp_req_q.pop_front();
                        chk("req_addr", imem_req_addr, ea);
                        last_gap = cyc - last_fire_cyc;
                        last_fire_cyc = cyc;
                    end
                end
                if (id_valid && id_ready) begin
                    if (exp_id_q.size() == 0) begin
                        fail_now("id_unexpected");
                    end else begin
                        ei = exp_id_q.pop_front();
                        chk("id_pc", id_pc, ei.pc);
                        chk("id_instr", id_instr, mem_word(ei.pc));
                        chk("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, ei.taken});
                        chk("id_pred_target", id_pred_target, ei.tgt);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_size(input int k);
        int n = 0;
        while (exp_req_q.size() > k && n < 300) begin
            tick();
            n++;
        end
        if (exp_req_q.size() > k) fail_now("req_wait_timeout");
    endtask

    task automatic wait_id_drain();
        int n = 0;
        while (exp_id_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_id_q.size() != 0) fail_now("id_wait_timeout");
    endtask

    task automatic push_id(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        id_exp_t e;
        e.pc = pc;
        e.taken = taken;
        e.tgt = tgt;
        exp_id_q.push_back(e);
    endtask

    task automatic redirect(input logic [31:0] pc);
        ex_redirect_en = 1'b1;
        ex_redirect_pc = pc;
        tick();
        ex_redirect_en = 1'b0;
    endtask

    task automatic run_fetch();
        imem_req_ready = 1'b1;
        wait_req_size(0);
        imem_req_ready = 1'b0;
        wait_id_drain();
    endtask

    initial begin : stimulus
        rst            = 1'b1;
        ex_redirect_en = 1'b0;
        ex_redirect_pc = 32'd0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        btb_en         = 1'b0;
        btb_hit_pc     = 32'd0;
        btb_tgt        = 32'd0;
        repeat (3) tick();

        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pred", {31'd0, id_pred_taken}, 32'd0);
        chk("rst_id_tgt", id_pred_target, 32'd0);
        chk("rst_lookup_pc", btb_lookup_pc, 32'h100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h100);
        tick();

        // Sequential fetch, 1-cycle memory
        exp_req_q.push_back(32'h100);
        exp_req_q.push_back(32'h104);
        exp_req_q.push_back(32'h108);
        push_id(32'h100, 1'b0, 32'h104);
        push_id(32'h104, 1'b0, 32'h108);
        push_id(32'h108, 1'b0, 32'h10C);
        run_fetch();
        chk("seq_req_gap", last_gap, 32'd2);

        // Redirect while request is held unaccepted, then a taken BTB hit
        redirect(32'h104);
        btb_en     = 1'b1;
        btb_hit_pc = 32'h104;
        btb_tgt    = 32'h200;
        exp_req_q.push_back(32'h104);
        exp_req_q.push_back(32'h200);
        push_id(32'h104, 1'b1, 32'h200);
        push_id(32'h200, 1'b0, 32'h204);
        run_fetch();
        btb_en = 1'b0;

        // Decode backpressure with a response waiting
        id_ready = 1'b0;
        exp_req_q.push_back(32'h204);
        exp_req_q.push_back(32'h208);
        push_id(32'h204, 1'b0, 32'h208);
        push_id(32'h208, 1'b0, 32'h20C);
        imem_req_ready = 1'b1;
        wait_req_size(0);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
            chk("bp_id_valid", {31'd0, id_valid}, 32'd1);
            chk("bp_id_pc", id_pc, 32'h204);
            chk("bp_id_instr", id_instr, mem_word(32'h204));
            tick();
        end
        id_ready = 1'b1;
        wait_id_drain();

        // Redirect while waiting; the in-flight response must be dropped
        mem_delay = 3;
        exp_req_q.push_back(32'h20C);
        exp_req_q.push_back(32'h400);
        push_id(32'h400, 1'b0, 32'h404);
        imem_req_ready = 1'b1;
        wait_req_size(1);
        redirect(32'h403);
        @(negedge clk);
        chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("drop_lookup_pc", btb_lookup_pc, 32'h400);
        for (int n = 0; n < 40 && exp_req_q.size() != 0; n++) begin
            @(negedge clk);
            chk("drop_id_valid", {31'd0, id_valid}, 32'd0);
            tick();
        end
        wait_req_size(0);
        imem_req_ready = 1'b0;
        wait_id_drain();
        mem_delay = 0;

        // Redirect coinciding with a response handshake and an id handshake
        id_ready = 1'b0;
        exp_req_q.push_back(32'h404);
        exp_req_q.push_back(32'h408);
        push_id(32'h404, 1'b0, 32'h408);
        imem_req_ready = 1'b1;
        wait_req_size(0);
        imem_req_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("coll_pre_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
        chk("coll_pre_id_valid", {31'd0, id_valid}, 32'd1);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        redirect(32'h500);
        @(negedge clk);
        chk("coll_id_valid", {31'd0, id_valid}, 32'd0);
        chk("coll_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("coll_req_addr", imem_req_addr, 32'h500);
        tick();
        wait_id_drain();

        // Back-to-back redirects, then address wrap
        redirect(32'h600);
        redirect(32'h700);
        redirect(32'hFFFF_FFFE);
        @(negedge clk);
        chk("b2b_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0000_0000);
        push_id(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        push_id(32'h0000_0000, 1'b0, 32'h0000_0004);
        run_fetch();

        repeat (3) tick();
        chk("end_req_q_empty", exp_req_q.size(), 32'd0);
        chk("end_id_q_empty", exp_id_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Sequencing controller for the fetch stage: owns the architectural fetch PC and drives one outstanding instruction-memory request at a time with valid/ready handshakes. Each fetched word is held in a one-entry output register for decode, together with the BTB prediction that steered the next fetch. An execute-stage redirect (taken jump/branch) overrides everything: queued output is killed and any in-flight memory response is discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset (bits [1:0] must be 0).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_redirect_en` in 1: execute-stage redirect request.
- `ex_redirect_pc` in 32: redirect target; bits [1:0] ignored and forced to 0.
- `btb_lookup_pc` out 32: equals `fetch_pc`. The BTB answers combinationally in the same cycle.
- `btb_pc_valid`, `btb_pc_predictTaken` in 1 each: BTB hit and taken prediction.
- `btb_target_pc` in 32: predicted target.
- `imem_req_valid` out 1, `imem_req_ready` in 1, `imem_req_addr` out 32: request channel.
- `imem_resp_valid` in 1, `imem_resp_ready` out 1, `imem_resp_data` in 32: response channel.
- `id_valid` out 1, `id_ready` in 1: output handshake to decode.
- `id_pc` out 32, `id_instr` out 32: PC and instruction of the buffered word.
- `id_pred_taken` out 1, `id_pred_target` out 32: prediction attached to the buffered word.

## Operation
- FSM states:
  - REQ: `imem_req_valid`=1, `imem_req_addr`=`fetch_pc`.
  - WAIT: request accepted, awaiting the response.
  - DROP: awaiting a response that must be discarded.
- REQ transitions:
  - On `imem_req_valid&&imem_req_ready` → WAIT.
  - In the same cycle, latch `pred_taken = btb_pc_valid&&btb_pc_predictTaken` and `pred_next = pred_taken ? btb_target_pc : fetch_pc+4`. The addition wraps modulo 2^32.
- WAIT behaviour:
  - `imem_resp_ready` = `!id_valid || id_ready`, i.e. the output register is free or draining.
  - On response handshake: load `id_pc`=`fetch_pc`, `id_instr`=`imem_resp_data`, `id_pred_taken`/`id_pred_target` from the latched values, and set `id_valid`=1.
  - In that same handshake cycle: `fetch_pc`←`pred_next` and go to REQ.
- DROP behaviour: `imem_resp_ready`=1; on response handshake the data is discarded and the state goes to REQ.
- Output register:
  - `id_valid` clears on `id_valid&&id_ready` unless it is reloaded in the same cycle.
  - Its contents are stable while `id_valid&&!id_ready`.
- Redirect has top priority. In the cycle `ex_redirect_en`=1:
  - `fetch_pc`←`{ex_redirect_pc[31:2],2'b00}`.
  - `id_valid`←0, even if a response handshake or an id handshake also happens that cycle.
  - REQ with the request accepted this cycle → DROP.
  - REQ with the request not accepted → stays REQ with the new address. This is the only legal address change while valid is held high.
  - WAIT with no response this cycle → DROP.
  - WAIT with a response this cycle → response consumed and discarded, go to REQ.
  - DROP → stays DROP, or goes to REQ if a response arrives this cycle.
- Back-to-back redirects: the last one wins.
- Request channel hold rule: once `imem_req_valid` is asserted, it stays high until accepted. The address is stable except on redirect.

## Timing
- Reset values while `rst`=1:
  - state REQ, `fetch_pc`=`RESET_PC`.
  - `imem_req_valid`=0, `imem_resp_ready`=0, `id_valid`=0.
  - `id_pc`, `id_instr`, `id_pred_target` = 0; `id_pred_taken`=0.
- First request: `imem_req_valid`=1 in the first cycle after `rst` deasserts.
- Asserting `rst` mid-transaction abandons the transaction. The memory side is required to be reset by the same `rst`.
- Latency:
  - Request accepted at cycle t → response accepted at t+k, k≥1 → `id_valid` at t+k+1.
  - Next request issued at t+k+1.
  - Peak throughput with a 1-cycle memory: one instruction per 2 cycles.
- Output register full with `id_ready`=0: `imem_resp_ready`=0, so memory holds the response and fetch stalls in WAIT.
- All outputs are registered except:
  - `imem_resp_ready`, which depends on `id_ready`.
  - `btb_lookup_pc`, which is a registered value passed through.

## Structure
- Shared package `fetch_ctrl_pkg`:
  - FSM state encoding (REQ=2'd0, WAIT=2'd1, DROP=2'd2).
  - Default `RESET_PC`.
  - PC increment constant 32'd4.
- Sub-module `fetch_next_pc`: combinational prediction mux (pc, BTB valid/taken/target → `pred_taken`, `pred_next`). Instantiated once.

## Test plan
- Reset release, `RESET_PC`=0x100, memory ready with 1-cycle latency, no BTB hit → requests to 0x100, 0x104, 0x108 on alternating cycles; `id_pc` in the same order; `id_pred_taken`=0.
- BTB hit taken at 0x104 with target 0x200 → next request address 0x200; buffered word has `id_pc`=0x104, `id_pred_taken`=1, `id_pred_target`=0x200.
- `id_ready`=0 for 5 cycles while a response is pending → `imem_resp_ready`=0 and `id_*` stable; after release the response is accepted and no word is lost or duplicated.
- Redirect to 0x403 while in WAIT, response arriving 3 cycles later → that response is dropped, next request address is 0x400, and `id_valid` is 0 until the 0x400 word returns.
- Redirect in the same cycle as a response handshake and an id handshake → `id_valid`=0 next cycle, state REQ, address equals the redirect target.
- `fetch_pc`=0xFFFF_FFFC with no prediction → next fetch address 0x0000_0000 (wrap).
